mod12_load_sched: RTL and testbench

//   Shares one loadable MOD-MODV up-counter among NREQ requesters.

---
 rtl/mod12_load_sched.sv | 125 ++++++++++++
 tb/tb_mod12_load_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mod12_load_sched.sv
// Round-robin scheduler sharing one loadable mod-MODV up-counter.
// Drives the counter's rst/load/din pins and watches its count for terminal.
module mod12_load_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int MODV = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        req_din,
  input  logic                     abort,
  input  logic [W-1:0]             cnt_q,
  output logic                     cnt_rst,
  output logic                     cnt_load,
  output logic [W-1:0]             cnt_din,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic                     done,
  output logic                     err_range
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  ptr_q, ptr_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic           load_q, load_d;
  logic [W-1:0]   din_q, din_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic           win_found;
  logic [OW-1:0]  win;
  logic [W-1:0]   pre;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win       = OW'((int'(ptr_q) + i) % NREQ);
      end
    end
    pre = req_din[int'(win)*W +: W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = '0;
    load_d  = 1'b0;
    din_d   = '0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_LOAD;
          owner_d = win;
          gnt_d   = NREQ'(1) << win;
          load_d  = 1'b1;
          err_d   = (pre >= W'(MODV));
          din_d   = err_d ? pre - W'(MODV) : pre;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        ptr_d   = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + OW'(1);
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == W'(MODV-1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      load_q  <= 1'b0;
      din_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      din_q   <= din_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cnt_rst   = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cnt_load  = load_q;
  assign cnt_din   = din_q;
  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign done      = done_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_mod12_load_sched.sv
// Bench for mod12_load_sched: directed scenarios then random traffic
// checked against a transaction-level round-robin model.
module tb_mod12_load_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int MODV = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_din;
  logic              abort;
  logic [W-1:0]      cnt_q;
  logic              cnt_rst;
  logic              cnt_load;
  logic [W-1:0]      cnt_din;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic              busy;
  logic              done;
  logic              err_range;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [NREQ-1:0] mask;
  logic [W-1:0]    din_arr [NREQ];
  int              m_ptr;
  int              last_wait;

  mod12_load_sched #(.NREQ(NREQ), .W(W), .MODV(MODV)) dut (
    .clk(clk), .rst(rst), .req(req), .req_din(req_din),
    .abort(abort), .cnt_q(cnt_q), .cnt_rst(cnt_rst),
    .cnt_load(cnt_load), .cnt_din(cnt_din), .gnt(gnt),
    .owner(owner), .busy(busy), .done(done),
    .err_range(err_range)
  );

  always #5 clk = ~clk;

  // The shared counter this block controls.
  always @(posedge clk) begin
    if (cnt_rst === 1'b1) cnt_q <= '0;
    else if (cnt_load === 1'b1) cnt_q <= cnt_din;
    else cnt_q <= (cnt_q == W'(MODV-1)) ? '0 : cnt_q + W'(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req = mask;
    for (int i = 0; i < NREQ; i++) req_din[i*W +: W] = din_arr[i];
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy, 0);
    chk("rst_cnt_rst", cnt_rst, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_load", cnt_load, 0);
    chk("rst_din", cnt_din, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_range, 0);
    chk("rst_owner", owner, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // One full ownership: expected winner, load value, run length and done.
  task automatic run_grant(input int abort_at);
    int  w, v, vv, len, exp_run, n;
    bit  seen, aborted;
    drive();
    w = -1;
    for (int i = 0; i < NREQ; i++)
      if (w < 0 && mask[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
    v  = int'(din_arr[w]);
    vv = (v >= MODV) ? v - MODV : v;
    len = MODV - vv;
    aborted = (abort_at > 0) && (abort_at <= len);
    exp_run = aborted ? abort_at : len;
    seen = 0;
    last_wait = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      last_wait++;
      if (gnt !== '0) seen = 1;
    end
    chk("gnt_seen", seen, 1);
    if (!seen) return;
    chk("gnt", gnt, 32'(1) << w);
    chk("owner", owner, w);
    chk("cnt_din", cnt_din, vv);
    chk("err_range", err_range, v >= MODV);
    chk("load", cnt_load, 1);
    chk("busy_load", busy, 1);
    chk("cnt_rst_load", cnt_rst, 0);
    mask[w] = 1'b0;
    drive();
    m_ptr = (w + 1) % NREQ;
    @(negedge clk);
    chk("gnt_pulse", gnt, 0);
    chk("cnt_first", cnt_q, vv);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == abort_at) abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    chk("run_len", n, exp_run);
    chk("done", done, !aborted);
    chk("cnt_rst_idle", cnt_rst, 1);
  endtask

  initial begin
    logic [NREQ-1:0] nw;
    int ab;
    rst = 1'b1;
    req = '0;
    req_din = '0;
    abort = 1'b0;
    mask = '0;
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) din_arr[i] = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;

    // single requester, preset 3
    mask = 4'b0001; din_arr[0] = 4'd3;
    run_grant(0);

    // all requesting, preset 10, strict rotation from 0
    do_reset();
    for (int i = 0; i < NREQ; i++) din_arr[i] = 4'd10;
    for (int r = 0; r < 5; r++) begin
      mask = 4'b1111;
      run_grant(0);
      chk("idle_gap", last_wait, 1);
    end

    // out-of-range preset
    mask = 4'b0100; din_arr[2] = 4'd14;
    run_grant(0);

    // boundary presets
    mask = 4'b0001; din_arr[0] = 4'd11;
    run_grant(0);
    mask = 4'b0001; din_arr[0] = 4'd0;
    run_grant(0);
    mask = 4'b0010; din_arr[1] = 4'd15;
    run_grant(0);

    // abort, then the still-pending requester
    mask = 4'b0011; din_arr[0] = 4'd0; din_arr[1] = 4'd0;
    run_grant(3);
    run_grant(0);

    // reset in RUN with requests pending
    for (int i = 0; i < NREQ; i++) din_arr[i] = 4'd0;
    mask = 4'b1110;
    drive();
    repeat (4) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs();
    rst = 1'b0;
    m_ptr = 0;
    mask = 4'b1111;
    run_grant(0);

    // random traffic
    for (int t = 0; t < 30; t++) begin
      nw = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        if (nw[i] && !mask[i]) begin
          mask[i] = 1'b1;
          din_arr[i] = W'($urandom_range(0, 15));
        end
      if (mask == '0) begin
        mask[t % NREQ] = 1'b1;
        din_arr[t % NREQ] = W'($urandom_range(0, 15));
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13)) : 0;
      run_grant(ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
